// File: rtl/video_timing_pkg.sv
// Shared timing types and helpers for the video timing generator.
// Provides the per-axis timing record, the line/frame total helper and 640x480 presets.
package video_timing_pkg;

    typedef struct packed {
        int   active;
        int   back_porch;
        int   front_porch;
        int   sync;
        logic polarity;
    } vtg_timing_t;

    localparam vtg_timing_t VTG_640x480_H = '{active: 32'd640, back_porch: 32'd48,
                                               front_porch: 32'd16, sync: 32'd96,
                                               polarity: 1'b0};
    localparam vtg_timing_t VTG_640x480_V = '{active: 32'd480, back_porch: 32'd33,
                                               front_porch: 32'd10, sync: 32'd2,
                                               polarity: 1'b0};

    function automatic int vtg_total(input vtg_timing_t t);
        return t.back_porch + t.active + t.front_porch + t.sync;
    endfunction

    // Bit width able to hold 0..n-1, never narrower than one bit.
    function automatic int vtg_width(input int n);
        return ($clog2(n) < 1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Output bundle of the video timing generator (coordinates, syncs, frame pulses).
// frame_cnt exists only when VTG_FRAME_CNT_EN is defined.
interface video_timing_gen_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9
`ifdef VTG_FRAME_CNT_EN
    , parameter int FRAME_CNT_WIDTH = 16
`endif
);
    logic [X_WIDTH-1:0]         x;
    logic [Y_WIDTH-1:0]         y;
    logic                       coord_valid;
    logic                       hs;
    logic                       vs;
    logic                       de;
    logic                       line_start;
    logic                       frame_start;
    logic                       swap;
`ifdef VTG_FRAME_CNT_EN
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
`endif

    modport master (
        output x, y, coord_valid, hs, vs, de, line_start, frame_start, swap
`ifdef VTG_FRAME_CNT_EN
        , frame_cnt
`endif
    );

    modport slave (
        input x, y, coord_valid, hs, vs, de, line_start, frame_start, swap
`ifdef VTG_FRAME_CNT_EN
        , frame_cnt
`endif
    );
endinterface

// File: rtl/video_timing_gen_delay_line.sv
// ce-gated shift register of configurable width and depth with a reset value.
// DEPTH of 0 degenerates to a combinational pass-through.
module vtg_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (WIDTH < 1 || DEPTH < 0 || DEPTH > 15) begin : g_param_err
        $error("vtg_delay_line: WIDTH must be >= 1 and DEPTH within 0..15");
    end

    if (DEPTH == 0) begin : g_pass
        logic unused_s;
        assign unused_s = ^{clk, rst, ce};
        assign dout     = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_r [DEPTH];

        // Shift one stage per ce; the whole line loads RESET_VAL on reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_r[i] <= RESET_VAL;
                end
            end else if (ce) begin
                stage_r[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_r[i] <= stage_r[i-1];
                end
            end
        end

        assign dout = stage_r[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: coordinates lead hs/vs/de by LOOKAHEAD ce steps.
// Optional completed-frame counter enabled by the VTG_FRAME_CNT_EN macro.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS      = VTG_640x480_H.active,
    parameter int HOR_BACK_PORCH_PIXELS  = VTG_640x480_H.back_porch,
    parameter int HOR_FRONT_PORCH_PIXELS = VTG_640x480_H.front_porch,
    parameter int HOR_SYNC_PIXELS        = VTG_640x480_H.sync,
    parameter bit HOR_SYNC_POLARITY      = VTG_640x480_H.polarity,
    parameter int VER_ACTIVE_PIXELS      = VTG_640x480_V.active,
    parameter int VER_BACK_PORCH_PIXELS  = VTG_640x480_V.back_porch,
    parameter int VER_FRONT_PORCH_PIXELS = VTG_640x480_V.front_porch,
    parameter int VER_SYNC_PIXELS        = VTG_640x480_V.sync,
    parameter bit VER_SYNC_POLARITY      = VTG_640x480_V.polarity,
    parameter int LOOKAHEAD              = 2,
    parameter int FRAME_CNT_WIDTH        = 16
) (
    input  logic                 clk_rgb,
    input  logic                 rst,
    input  logic                 ce,
    video_timing_gen_if.master   vid
);

    localparam vtg_timing_t H_TIM = '{active: HOR_ACTIVE_PIXELS, back_porch: HOR_BACK_PORCH_PIXELS,
                                      front_porch: HOR_FRONT_PORCH_PIXELS, sync: HOR_SYNC_PIXELS,
                                      polarity: HOR_SYNC_POLARITY};
    localparam vtg_timing_t V_TIM = '{active: VER_ACTIVE_PIXELS, back_porch: VER_BACK_PORCH_PIXELS,
                                      front_porch: VER_FRONT_PORCH_PIXELS, sync: VER_SYNC_PIXELS,
                                      polarity: VER_SYNC_POLARITY};
    localparam int HT      = vtg_total(H_TIM);
    localparam int VT      = vtg_total(V_TIM);
    localparam int HW      = vtg_width(HT);
    localparam int VW      = vtg_width(VT);
    localparam int X_WIDTH = vtg_width(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH = vtg_width(VER_ACTIVE_PIXELS);
    localparam int H_ACT_END    = H_TIM.back_porch + H_TIM.active;
    localparam int V_ACT_END    = V_TIM.back_porch + V_TIM.active;
    localparam int H_SYNC_START = H_ACT_END + H_TIM.front_porch;
    localparam int V_SYNC_START = V_ACT_END + V_TIM.front_porch;

    if (HOR_ACTIVE_PIXELS < 1 || HOR_BACK_PORCH_PIXELS < 1 || HOR_FRONT_PORCH_PIXELS < 1 ||
        HOR_SYNC_PIXELS < 1 || VER_ACTIVE_PIXELS < 1 || VER_BACK_PORCH_PIXELS < 1 ||
        VER_FRONT_PORCH_PIXELS < 1 || VER_SYNC_PIXELS < 1 || LOOKAHEAD < 0 || LOOKAHEAD > 15 ||
        FRAME_CNT_WIDTH < 1) begin : g_param_err
        $error("video_timing_gen: porch/sync/active must be >= 1 and LOOKAHEAD within 0..15");
    end

    logic [HW-1:0]      h_cnt_r, h_nxt_s;
    logic [VW-1:0]      v_cnt_r, v_nxt_s;
    logic               h_wrap_s, frame_wrap_s;
    logic [X_WIDTH-1:0] x_r, x_nxt_s;
    logic [Y_WIDTH-1:0] y_r, y_nxt_s;
    logic               cv_r, cv_nxt_s;
    logic               hs_raw_r, hs_nxt_s;
    logic               vs_raw_r, vs_nxt_s;
    logic               swap_r;
    logic [2:0]         dly_s;

    // Next raster position; registers only take it when ce is high.
    always_comb begin
        h_wrap_s     = (h_cnt_r == HW'(HT - 1));
        frame_wrap_s = h_wrap_s && (v_cnt_r == VW'(VT - 1));
        h_nxt_s      = h_cnt_r + HW'(1);
        v_nxt_s      = v_cnt_r;
        if (h_wrap_s) begin
            h_nxt_s = '0;
            if (v_cnt_r == VW'(VT - 1)) begin
                v_nxt_s = '0;
            end else begin
                v_nxt_s = v_cnt_r + VW'(1);
            end
        end else begin
            v_nxt_s = v_cnt_r;
        end
    end

    // Decode the next position so the registered stage-0 values line up with the counters.
    always_comb begin
        cv_nxt_s = (h_nxt_s >= HW'(H_TIM.back_porch)) && (h_nxt_s < HW'(H_ACT_END)) &&
                   (v_nxt_s >= VW'(V_TIM.back_porch)) && (v_nxt_s < VW'(V_ACT_END));
        if (cv_nxt_s) begin
            x_nxt_s = X_WIDTH'(h_nxt_s - HW'(H_TIM.back_porch));
            y_nxt_s = Y_WIDTH'(v_nxt_s - VW'(V_TIM.back_porch));
        end else begin
            x_nxt_s = '0;
            y_nxt_s = '0;
        end
        hs_nxt_s = (h_nxt_s >= HW'(H_SYNC_START)) ? HOR_SYNC_POLARITY : ~HOR_SYNC_POLARITY;
        vs_nxt_s = (v_nxt_s >= VW'(V_SYNC_START)) ? VER_SYNC_POLARITY : ~VER_SYNC_POLARITY;
    end

    // Raster counters.
    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (ce) begin
            h_cnt_r <= h_nxt_s;
            v_cnt_r <= v_nxt_s;
        end
    end

    // Stage-0 outputs and the one-step swap pulse raised by the frame wrap.
    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            x_r      <= '0;
            y_r      <= '0;
            cv_r     <= 1'b0;
            hs_raw_r <= ~HOR_SYNC_POLARITY;
            vs_raw_r <= ~VER_SYNC_POLARITY;
            swap_r   <= 1'b0;
        end else if (ce) begin
            x_r      <= x_nxt_s;
            y_r      <= y_nxt_s;
            cv_r     <= cv_nxt_s;
            hs_raw_r <= hs_nxt_s;
            vs_raw_r <= vs_nxt_s;
            swap_r   <= frame_wrap_s;
        end
    end

    vtg_delay_line #(
        .WIDTH     (3),
        .DEPTH     (LOOKAHEAD),
        .RESET_VAL ({~HOR_SYNC_POLARITY, ~VER_SYNC_POLARITY, 1'b0})
    ) u_sync_dly (
        .clk  (clk_rgb),
        .rst  (rst),
        .ce   (ce),
        .din  ({hs_raw_r, vs_raw_r, cv_r}),
        .dout (dly_s)
    );

`ifdef VTG_FRAME_CNT_EN
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_r;

    // Completed-frame count, bumped together with the swap pulse.
    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= '0;
        end else if (ce && frame_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + FRAME_CNT_WIDTH'(1);
        end
    end

    assign vid.frame_cnt = frame_cnt_r;
`endif

    assign vid.x           = x_r;
    assign vid.y           = y_r;
    assign vid.coord_valid = cv_r;
    assign vid.hs          = dly_s[2];
    assign vid.vs          = dly_s[1];
    assign vid.de          = dly_s[0];
    assign vid.line_start  = (h_cnt_r == '0);
    assign vid.frame_start = (h_cnt_r == '0) && (v_cnt_r == '0);
    assign vid.swap        = swap_r;

endmodule
